// File: rtl/snitch_icache_event_counters.sv
// snitch_icache_event_counters: nine-entry instruction-cache event counter bank with shadow readout.
// Define SNITCH_ICACHE_EVENT_OVF_IRQ_EN to add sticky per-counter overflow flags and the overflow irq.
package snitch_icache_event_pkg;
    typedef struct packed {
        logic l0_miss;
        logic l0_hit;
        logic l0_prefetch;
        logic l0_double_hit;
        logic l0_stall;
    } icache_l0_events_t;

    typedef struct packed {
        logic l1_miss;
        logic l1_hit;
        logic l1_stall;
        logic l1_handler_stall;
    } icache_l1_events_t;
endpackage

module snitch_icache_event_counters
    import snitch_icache_event_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter bit          SATURATE       = 1'b0,
    localparam int unsigned NUM_CNT       = 9,
    localparam int unsigned AW            = $clog2(NUM_CNT)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
    input  icache_l1_events_t                      l1_events_i,
    input  logic                                   enable_i,
    input  logic                                   clear_i,
    input  logic                                   snapshot_i,
    input  logic                                   rd_req_i,
    input  logic [AW-1:0]                          rd_addr_i,
    output logic                                   rd_valid_o,
    output logic [CNT_WIDTH-1:0]                   rd_data_o,
    output logic                                   rd_err_o,
    output logic [NUM_CNT-1:0]                     ovf_o,
    output logic                                   irq_o
);
    localparam int unsigned SW = CNT_WIDTH + 1;

    logic [CNT_WIDTH-1:0] live_q   [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] live_d   [NUM_CNT];
    logic [SW-1:0]        inc      [NUM_CNT];
    logic [SW-1:0]        sum      [NUM_CNT];
    logic [NUM_CNT-1:0]   carry;

    // L0 increments are the per-field popcount across ports; L1 increments are single bits.
    always_comb begin
        for (int c = 0; c < NUM_CNT; c++) inc[c] = '0;
        for (int p = 0; p < NR_FETCH_PORTS; p++) begin
            inc[0] = inc[0] + SW'(l0_events_i[p].l0_miss);
            inc[1] = inc[1] + SW'(l0_events_i[p].l0_hit);
            inc[2] = inc[2] + SW'(l0_events_i[p].l0_prefetch);
            inc[3] = inc[3] + SW'(l0_events_i[p].l0_double_hit);
            inc[4] = inc[4] + SW'(l0_events_i[p].l0_stall);
        end
        inc[5] = SW'(l1_events_i.l1_miss);
        inc[6] = SW'(l1_events_i.l1_hit);
        inc[7] = SW'(l1_events_i.l1_stall);
        inc[8] = SW'(l1_events_i.l1_handler_stall);
    end

    always_comb begin
        for (int c = 0; c < NUM_CNT; c++) begin
            sum[c]    = {1'b0, live_q[c]} + inc[c];
            carry[c]  = sum[c][CNT_WIDTH];
            live_d[c] = (SATURATE && carry[c]) ? '1 : sum[c][CNT_WIDTH-1:0];
        end
    end

    // Snapshot copies the pre-edge live values, so a same-cycle clear still lands in the shadow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CNT; c++) begin
                live_q[c]   <= '0;
                shadow_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CNT; c++) begin
                if (snapshot_i) shadow_q[c] <= live_q[c];
                if (clear_i) live_q[c] <= '0;
                else if (enable_i) live_q[c] <= live_d[c];
            end
        end
    end

    // Read protocol: rd_req_i is always accepted; rd_valid_o pulses exactly one cycle later with
    // the shadow value sampled at the request edge. rd_data_o holds between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_err_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                if (rd_addr_i < AW'(NUM_CNT)) begin
                    rd_data_o <= shadow_q[rd_addr_i];
                    rd_err_o  <= 1'b0;
                end else begin
                    rd_data_o <= '0;
                    rd_err_o  <= 1'b1;
                end
            end
        end
    end

`ifdef SNITCH_ICACHE_EVENT_OVF_IRQ_EN
    logic [NUM_CNT-1:0] ovf_q;
    logic [NUM_CNT-1:0] ovf_d;
    logic               irq_q;

    assign ovf_d = ovf_q | (carry & {NUM_CNT{enable_i}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else if (clear_i) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= |ovf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign irq_o = irq_q;
`else
    assign ovf_o = '0;
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_snitch_icache_event_counters.sv
// Testbench for snitch_icache_event_counters: directed literal checks plus randomized traffic
// compared every cycle against a behavioural counter model.
module tb_snitch_icache_event_counters;
    import snitch_icache_event_pkg::*;

    localparam int NP   = 2;
    localparam int W    = 8;
    localparam bit SAT  = 1'b0;
    localparam int NC   = 9;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic                       clk = 1'b0;
    logic                       rst;
    icache_l0_events_t [NP-1:0] l0_ev;
    icache_l1_events_t          l1_ev;
    logic                       enable, clear, snapshot, rd_req;
    logic [3:0]                 rd_addr;
    logic                       rd_valid_o, rd_err_o, irq_o;
    logic [W-1:0]               rd_data_o;
    logic [NC-1:0]              ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    snitch_icache_event_counters #(
        .NR_FETCH_PORTS (NP),
        .CNT_WIDTH      (W),
        .SATURATE       (SAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .l0_events_i (l0_ev),
        .l1_events_i (l1_ev),
        .enable_i    (enable),
        .clear_i     (clear),
        .snapshot_i  (snapshot),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_err_o    (rd_err_o),
        .ovf_o       (ovf_o),
        .irq_o       (irq_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model
    longint        live_m   [NC];
    longint        shadow_m [NC];
    logic [NC-1:0] ovf_m;
    bit            exp_valid;
    logic [W:0]    exp_q[$];
    longint        m_s;
    bit            m_of;

    function automatic int ev_count(input int c);
        int n = 0;
        for (int p = 0; p < NP; p++) begin
            case (c)
                0: n += int'(l0_ev[p].l0_miss);
                1: n += int'(l0_ev[p].l0_hit);
                2: n += int'(l0_ev[p].l0_prefetch);
                3: n += int'(l0_ev[p].l0_double_hit);
                4: n += int'(l0_ev[p].l0_stall);
                default: ;
            endcase
        end
        case (c)
            5: n = int'(l1_ev.l1_miss);
            6: n = int'(l1_ev.l1_hit);
            7: n = int'(l1_ev.l1_stall);
            8: n = int'(l1_ev.l1_handler_stall);
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                live_m[c]   = 0;
                shadow_m[c] = 0;
            end
            ovf_m     = '0;
            exp_valid = 1'b0;
            exp_q.delete();
        end else begin
            exp_valid = rd_req;
            if (rd_req) begin
                if (rd_addr >= NC) exp_q.push_back({1'b1, {W{1'b0}}});
                else exp_q.push_back({1'b0, W'(shadow_m[rd_addr])});
            end
            if (snapshot) for (int c = 0; c < NC; c++) shadow_m[c] = live_m[c];
            for (int c = 0; c < NC; c++) begin
                m_s  = live_m[c];
                m_of = 1'b0;
                if (enable) begin
                    m_s = m_s + ev_count(c);
                    if (m_s > MAXV) begin
                        m_of = 1'b1;
                        m_s  = SAT ? MAXV : m_s - (MAXV + 1);
                    end
                end
                if (clear) live_m[c] = 0;
                else begin
                    live_m[c] = m_s;
                    if (m_of) ovf_m[c] = 1'b1;
                end
            end
            if (clear) ovf_m = '0;
        end
    end

    // scoreboard: every negedge
    logic [W:0]    sb_e;
    logic [NC-1:0] exp_ovf;
    always @(negedge clk) begin
`ifdef SNITCH_ICACHE_EVENT_OVF_IRQ_EN
        exp_ovf = ovf_m;
`else
        exp_ovf = '0;
`endif
        check("sb_rd_valid", 64'(rd_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_queue_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_rd_data", 64'(rd_data_o), 64'(sb_e[W-1:0]));
                check("sb_rd_err", 64'(rd_err_o), 64'(sb_e[W]));
            end
        end
        check("sb_ovf", 64'(ovf_o), 64'(exp_ovf));
        check("sb_irq", 64'(irq_o), 64'(|exp_ovf));
    end

    // driver tasks
    task automatic set_idle();
        l0_ev    = '0;
        l1_ev    = '0;
        clear    = 1'b0;
        snapshot = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        set_idle();
        clear = 1'b1;
        tick(1);
        set_idle();
    endtask

    task automatic pulse_snapshot();
        set_idle();
        snapshot = 1'b1;
        tick(1);
        set_idle();
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [W-1:0] exp_d, input logic exp_e,
                           input string name);
        rd_req  = 1'b1;
        rd_addr = addr;
        tick(1);
        set_idle();
        check({name, "_valid"}, 64'(rd_valid_o), 64'd1);
        check({name, "_data"}, 64'(rd_data_o), 64'(exp_d));
        check({name, "_err"}, 64'(rd_err_o), 64'(exp_e));
    endtask

    logic exp_flag;

    initial begin
        set_idle();
        enable  = 1'b0;
        rd_addr = '0;
        rst     = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset_rd_valid", 64'(rd_valid_o), 64'd0);
        check("reset_rd_data", 64'(rd_data_o), 64'd0);
        check("reset_ovf", 64'(ovf_o), 64'd0);
        check("reset_irq", 64'(irq_o), 64'd0);

        // reset asserted asynchronously mid-count
        enable = 1'b1;
        l1_ev.l1_hit = 1'b1;
        tick(10);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(rd_valid_o), 64'd0);
        check("async_rst_data", 64'(rd_data_o), 64'd0);
        check("async_rst_err", 64'(rd_err_o), 64'd0);
        check("async_rst_ovf", 64'(ovf_o), 64'd0);
        check("async_rst_irq", 64'(irq_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        pulse_snapshot();
        do_read(4'd6, 8'd0, 1'b0, "rst_idx6");

        // multi-port aggregation: 5 cycles x2 + 3 cycles x1 = 13
        pulse_clear();
        l0_ev[0].l0_hit = 1'b1;
        l0_ev[1].l0_hit = 1'b1;
        tick(5);
        l0_ev[1].l0_hit = 1'b0;
        tick(3);
        pulse_snapshot();
        do_read(4'd1, 8'd13, 1'b0, "multi_hit");

        // enable gating
        pulse_clear();
        enable = 1'b0;
        l0_ev[0].l0_miss = 1'b1;
        tick(4);
        enable = 1'b1;
        tick(4);
        pulse_snapshot();
        do_read(4'd0, 8'd4, 1'b0, "gated_miss");

        // clear / snapshot / read race
        pulse_clear();
        l1_ev.l1_miss = 1'b1;
        tick(3);
        pulse_snapshot();
        l1_ev.l1_miss = 1'b1;
        tick(4);
        set_idle();
        l1_ev.l1_miss = 1'b1;
        clear         = 1'b1;
        snapshot      = 1'b1;
        do_read(4'd5, 8'd3, 1'b0, "race_old_shadow");
        do_read(4'd5, 8'd7, 1'b0, "race_pre_clear");
        pulse_snapshot();
        do_read(4'd5, 8'd0, 1'b0, "race_after_clear");

        // wrap / saturate at the counter boundary
        pulse_clear();
        l0_ev[0].l0_stall = 1'b1;
        l0_ev[1].l0_stall = 1'b1;
        tick(127);
        pulse_snapshot();
        do_read(4'd4, 8'd254, 1'b0, "stall_254");
        l0_ev[0].l0_stall = 1'b1;
        l0_ev[1].l0_stall = 1'b1;
        tick(1);
        pulse_snapshot();
        do_read(4'd4, SAT ? 8'd255 : 8'd0, 1'b0, "stall_boundary");
`ifdef SNITCH_ICACHE_EVENT_OVF_IRQ_EN
        exp_flag = 1'b1;
`else
        exp_flag = 1'b0;
`endif
        check("stall_ovf4", 64'(ovf_o[4]), 64'(exp_flag));
        check("stall_irq", 64'(irq_o), 64'(exp_flag));

        // out-of-range address
        do_read(4'd12, 8'd0, 1'b1, "bad_addr");

        // randomized traffic
        pulse_clear();
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < NP; p++) l0_ev[p] = icache_l0_events_t'($urandom_range(0, 31));
            l1_ev    = icache_l1_events_t'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 299) == 0);
            snapshot = ($urandom_range(0, 7) == 0);
            rd_req   = $urandom_range(0, 1) == 1;
            rd_addr  = 4'($urandom_range(0, 15));
            tick(1);
        end
        set_idle();
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
